// File: rtl/serial_link_pkg.sv
// Shared types and constants for the single-bit serial sequence link (transmitter and detector).
// SERIAL_PATTERN_TX_PARITY_EN enables the trailing even-parity bit; the parity helper lives here so both ends agree.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        PARITY
    } link_state_t;

    localparam int   DEFAULT_WIDTH      = 8;
    localparam int   DEFAULT_GAP        = 2;
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Words narrower than 32 bits are zero-extended by the caller, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register that feeds the serial transmitter; the MSB is the next bit to send.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (clear) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = data[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready and sends it MSB-first, followed by an idle gap.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit after the last data bit.
module serial_pattern_tx
    import serial_link_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   GAP_CYCLES = DEFAULT_GAP,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    link_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       gap_cnt;
    logic             next_msb;
    logic             accept;

    assign data_ready = (state == IDLE) && !clear;
    assign accept     = data_valid && data_ready;

    // The register is loaded already shifted by one: the MSB goes straight to out on the accept edge.
    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     ((state == SHIFT) && !clear),
        .clear     (clear),
        .load_data ({data_in[WIDTH-2:0], 1'b0}),
        .msb       (next_msb)
    );

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (clear) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= even_parity(32'(data_in));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            out         <= IDLE_LEVEL;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            out         <= IDLE_LEVEL;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        state       <= SHIFT;
                        bit_cnt     <= LAST_BIT;
                        out         <= data_in[WIDTH-1];
                        out_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                        out     <= next_msb;
                    end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        state <= PARITY;
                        out   <= parity_bit;
`else
                        out       <= IDLE_LEVEL;
                        out_valid <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                PARITY: begin
                    out       <= IDLE_LEVEL;
                    out_valid <= 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= IDLE_LEVEL;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: a cycle-slot model of each frame plus directed literal checks.
module tb_serial_pattern_tx;

    localparam int W   = 8;
    localparam int GAP = 2;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_BITS = W + PAR;
    localparam int PERIOD     = FRAME_BITS + GAP + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic         out;
    logic         out_valid;
    logic         frame_start;
    logic         busy;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 1'b0;

    logic [63:0] streamBits = '0;
    int          streamLen  = 0;

    serial_pattern_tx #(
        .WIDTH      (W),
        .GAP_CYCLES (GAP),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Each cycle of a frame is one slot: expected bit, valid, frame-start and busy.
    typedef struct packed {
        logic o;
        logic v;
        logic fs;
        logic b;
    } slot_t;

    localparam slot_t IDLE_SLOT = 4'b0000;

    slot_t cur = IDLE_SLOT;
    slot_t pending[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: a word accepted while idle expands into its full list of output slots.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                cur = IDLE_SLOT;
                pending.delete();
            end else if (clear) begin
                cur = IDLE_SLOT;
                pending.delete();
            end else if (!cur.b && data_valid) begin
                slot_t s;
                logic [W-1:0] d;
                d = data_in;
                for (int i = W - 1; i >= 0; i--) begin
                    s.o = d[i]; s.v = 1'b1; s.fs = (i == W - 1); s.b = 1'b1;
                    pending.push_back(s);
                end
                if (PAR != 0) begin
                    s.o = ^d; s.v = 1'b1; s.fs = 1'b0; s.b = 1'b1;
                    pending.push_back(s);
                end
                for (int g = 0; g < GAP; g++) begin
                    s = IDLE_SLOT; s.b = 1'b1;
                    pending.push_back(s);
                end
                cur = pending.pop_front();
            end else if (pending.size() > 0) begin
                cur = pending.pop_front();
            end else begin
                cur = IDLE_SLOT;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("model_out", 64'(out), 64'(cur.o));
                checkOutput("model_out_valid", 64'(out_valid), 64'(cur.v));
                checkOutput("model_frame_start", 64'(frame_start), 64'(cur.fs));
                checkOutput("model_busy", 64'(busy), 64'(cur.b));
                checkOutput("model_data_ready", 64'(data_ready), 64'(!cur.b && !clear));
                if (out_valid) begin
                    streamBits = {streamBits[62:0], out};
                    streamLen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Holds data_valid until the DUT takes the word; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] word, output int waitCycles);
        bit accepted;
        bit rdy;
        accepted   = 1'b0;
        waitCycles = 0;
        data_in    = word;
        data_valid = 1'b1;
        for (int n = 0; n < 64 && !accepted; n++) begin
            @(negedge clk);
            rdy = data_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted   = 1'b1;
                waitCycles = n;
            end
        end
        if (!accepted) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept of %0h", word);
        end
    endtask

    task automatic resetStream();
        streamBits = '0;
        streamLen  = 0;
    endtask

    initial begin
        int wc;
        logic [63:0] expStream;
        logic [W-1:0] pat;

        @(posedge clk);
        checkEn = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_out", 64'(out), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ready", 64'(data_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] single frame 0x0A");
        resetStream();
        pat = 8'b0000_1010;
        applyStimulus(pat, wc);
        data_valid = 1'b0;
        for (int i = 1; i <= FRAME_BITS + GAP + 1; i++) begin
            @(negedge clk);
            if (i <= W) begin
                checkOutput($sformatf("single_bit%0d", i), 64'(out), 64'(pat[W-i]));
                checkOutput($sformatf("single_fs%0d", i), 64'(frame_start), 64'(i == 1));
            end
            checkOutput($sformatf("single_valid%0d", i), 64'(out_valid), 64'(i <= FRAME_BITS));
            if (i == FRAME_BITS + GAP + 1) begin
                checkOutput("single_ready_again", 64'(data_ready), 64'd1);
                checkOutput("single_idle_busy", 64'(busy), 64'd0);
            end
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        expStream = 64'({8'h0A, 1'b0});
`else
        expStream = 64'h0A;
`endif
        checkOutput("single_stream", streamBits, expStream);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back 0xA5 then 0x3C");
        resetStream();
        applyStimulus(8'hA5, wc);
        applyStimulus(8'h3C, wc);
        checkOutput("b2b_accept_spacing", 64'(wc + 1), 64'(PERIOD));
        data_valid = 1'b0;
        repeat (PERIOD + 1) @(posedge clk);
        #1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        expStream = 64'({8'hA5, 1'b0, 8'h3C, 1'b0});
`else
        expStream = 64'hA53C;
`endif
        checkOutput("b2b_stream", streamBits, expStream);
        checkOutput("b2b_stream_len", 64'(streamLen), 64'(2 * FRAME_BITS));

        $display("[TB] valid while busy");
        resetStream();
        applyStimulus(8'h96, wc);
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        data_in    = 8'hFF;
        data_valid = 1'b1;
        @(negedge clk);
        checkOutput("busy_ready_low", 64'(data_ready), 64'd0);
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (PERIOD + 2) @(posedge clk);
        #1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        expStream = 64'({8'h96, 1'b0});
`else
        expStream = 64'h96;
`endif
        checkOutput("busy_stream", streamBits, expStream);

        $display("[TB] clear mid-frame with simultaneous valid");
        resetStream();
        applyStimulus(8'hF0, wc);
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear      = 1'b1;
        data_in    = 8'h55;
        data_valid = 1'b1;
        @(negedge clk);
        checkOutput("clear_bit4", 64'(out), 64'd1);
        checkOutput("clear_ready_low", 64'(data_ready), 64'd0);
        @(posedge clk);
        #1;
        clear      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        checkOutput("clear_out", 64'(out), 64'd0);
        checkOutput("clear_out_valid", 64'(out_valid), 64'd0);
        checkOutput("clear_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("clear_stream_len", 64'(streamLen), 64'd4);
        checkOutput("clear_stream", streamBits, 64'hF);

        $display("[TB] async reset on bit 5");
        resetStream();
        applyStimulus(8'hFF, wc);
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("areset_pre_out", 64'(out), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("areset_out", 64'(out), 64'd0);
        checkOutput("areset_busy", 64'(busy), 64'd0);
        checkOutput("areset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("areset_stream_len", 64'(streamLen), 64'd4);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        $display("[TB] parity frame 0xB0");
        resetStream();
        applyStimulus(8'b1011_0000, wc);
        data_valid = 1'b0;
        repeat (PERIOD + 1) @(posedge clk);
        #1;
        checkOutput("parity_len", 64'(streamLen), 64'd9);
        checkOutput("parity_stream", streamBits, 64'({8'hB0, 1'b1}));
`endif

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit side of the single-bit serial sequence link; the sequence-detector FSM is the receive side.
- Accepts a parallel WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first on `out`, one bit per clock.
- Frames are separated by a programmable idle gap.
- Used as the stimulus source that drives detector `in` pins inside the design and on benches.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- GAP_CYCLES, 2, idle cycles inserted after each frame; legal range 0..15.
- IDLE_LEVEL, 1'b0, value driven on `out` when no frame bit is active.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns the block to IDLE on the next edge.
- data_in  input  WIDTH  word to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit stream.
- out_valid  output  1  `out` carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse coinciding with the first (MSB) bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - out=IDLE_LEVEL, out_valid=0, frame_start=0, busy=0.
  - data_ready=1 once rst is deasserted.
- All outputs are registered except data_ready, which is defined as (state==IDLE && !clear).
- States: IDLE, SHIFT, GAP (and PARITY when the optional feature is compiled in).
- IDLE:
  - Accept on data_valid && data_ready: latch data_in, go to SHIFT, load bit counter = WIDTH-1.
  - On that edge: out=data_in[WIDTH-1], out_valid=1, frame_start=1.
- SHIFT:
  - Each edge: shift left, out = next bit, decrement counter; frame_start=0.
  - Bits appear on out in cycles k+1 .. k+WIDTH after an accept at edge k.
  - When counter==0 at an edge:
    - GAP_CYCLES>0: go to GAP, out=IDLE_LEVEL, out_valid=0, gap counter loaded to GAP_CYCLES-1.
    - GAP_CYCLES==0: go straight to IDLE.
- GAP: out held at IDLE_LEVEL, out_valid=0; decrement gap counter; go to IDLE when it reaches 0.
- data_valid outside IDLE is ignored; the word is not consumed, and the source must hold it until data_ready.
- Minimum frame period is WIDTH+GAP_CYCLES+1 cycles (the IDLE cycle is mandatory between frames).
- clear:
  - From any state, the next edge goes to IDLE with out=IDLE_LEVEL, out_valid=0, frame_start=0, counters=0.
  - clear and data_valid in the same cycle: clear wins; data_ready=0, so the word is not accepted.
- Reset mid-frame: the frame is truncated immediately, asynchronously; no partial bits are resumed afterwards.
- Counter widths:
  - Bit counter: $clog2(WIDTH).
  - Gap counter: 4 bits.
  - Neither counter may wrap below zero; terminal-count checks are on ==0.

Optional Feature:
- Macro SERIAL_PATTERN_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle.
  - During PARITY: out = even parity (XOR of all WIDTH data bits), out_valid=1. Then it proceeds to GAP or IDLE as above.
  - Frame period grows by 1 cycle.
  - clear in PARITY behaves as in any other state.
- Undefined: no PARITY state exists; frame is WIDTH bits.

Decomposition:
- Package serial_link_pkg holds:
  - State enum type: IDLE, SHIFT, GAP, PARITY.
  - Constants: DEFAULT_WIDTH=8, DEFAULT_GAP=2, IDLE_LEVEL_DEFAULT=1'b0.
  - Shared parity function, so the detector side can check the same parity.
- One sub-module, piso_shift_reg: WIDTH-bit parallel-load, shift-left register with load, shift and clear controls, exposing its MSB.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Reset then idle (rst low 2 cycles, no valid) -> out=0, out_valid=0, busy=0, data_ready=1.
- Single frame (WIDTH=8, GAP=2, data_in=8'b0000_1010 accepted at edge k):
  - out = 0,0,0,0,1,0,1,0 in cycles k+1..k+8, with frame_start high only in k+1.
  - out_valid=0 in k+9..k+10; data_ready=1 again at k+11.
- Back-to-back (data_valid held high with 8'hA5 then 8'h3C):
  - Second accept occurs exactly 11 cycles after the first.
  - Bit stream is 10100101, then 2 idle cycles, then 00111100.
- Valid while busy (pulse data_valid with 8'hFF mid-frame) -> ignored; current frame bits unchanged; data_ready stays 0 until IDLE.
- Clear mid-frame (assert clear on the 4th bit of 8'hF0) -> next cycle out=0, out_valid=0, state IDLE; clear+valid in the same cycle -> no accept.
- Async reset on bit 5 -> out=IDLE_LEVEL and busy=0 immediately, without a clock edge.
- With SERIAL_PATTERN_TX_PARITY_EN, 8'b1011_0000 -> 9th bit is 1 and the frame is 9 cycles.
